sprite_animator: RTL and testbench
==================================

# sprite_animator

Parametrised, pipelined sprite renderer for the 96x64 RGB565 OLED path. It replaces the fixed, position-locked, single-image sprite lookups with one block that handles position, horizontal flip, multi-frame animation and colour-key transparency. The bitmap data sits in an external synchronous ROM. The block sits between the OLED pixel_index generator and the layer compositor, and produces one 16-bit colour plus an opacity flag per pixel.

## Interface
Parameters:
- SCREEN_W, 96, display width in pixels
- SCREEN_H, 64, display height in pixels
- SPR_W, 32, sprite width in pixels
- SPR_H, 32, sprite height in pixels
- N_FRAMES, 4, number of animation frames in the ROM (at least 1)
- FRAME_TICKS, 6, display frames shown per animation frame (at least 1)
- KEY_COLOUR, 16'h0000, transparent colour
- AW, $clog2(N_FRAMES*SPR_W*SPR_H), ROM address width

Ports:
- clk, in, 1, system clock
- reset, in, 1, synchronous, active-high
- pixel_index, in, 13, raster index, row-major, x = index % SCREEN_W, y = index / SCREEN_W
- frame_begin, in, 1, one-cycle pulse at the start of each display frame
- pos_x, in, 7, sprite top-left x (live value)
- pos_y, in, 6, sprite top-left y (live value)
- flip_h, in, 1, mirror the sprite horizontally (live value)
- loop_mode, in, 1, 1 = loop the animation, 0 = one-shot
- anim_start, in, 1, pulse that starts or restarts the animation at frame 0
- rom_addr, out, AW, ROM address
- rom_data, in, 16, ROM read data, valid one cycle after rom_addr
- oled_colour, out, 16, rendered colour, 0 when not opaque
- opaque, out, 1, 1 = oled_colour is a sprite pixel
- frame_sel, out, $clog2(N_FRAMES) (minimum width 1), current animation frame
- anim_busy, out, 1, high in PLAY
- anim_done, out, 1, one-cycle pulse when a one-shot animation finishes

## Operation
- **Shadow registers.** pos_x, pos_y and flip_h are latched into shadow registers only on cycles where frame_begin = 1. Rendering uses the shadow values only, so the sprite never tears mid-frame.
- **Pixel pipeline**
  - S0 (combinational): derive x and y from pixel_index. The divide by a constant must be synthesisable.
  - S1 (registered):
    - in_box = (x >= sx) && (x < sx+SPR_W) && (y >= sy) && (y < sy+SPR_H), computed at 8 bits so the sum cannot overflow.
    - lx = x-sx, or SPR_W-1-(x-sx) when the shadow flip is set.
    - ly = y-sy.
    - rom_addr = frame_sel*SPR_W*SPR_H + ly*SPR_W + lx.
    - When in_box = 0, rom_addr is held at 0.
    - in_box is piped forward to S2.
  - S2 (registered): opaque = in_box_d && (rom_data != KEY_COLOUR). oled_colour = opaque ? rom_data : 0.
- **Clipping.** Any part of the sprite beyond the screen edge is not drawn. There is no wrap-around.
- **Animation FSM.** States are IDLE, PLAY and DONE.
  - IDLE: frame_sel = 0, tick = 0. anim_start moves to PLAY.
  - PLAY:
    - Each frame_begin increments tick.
    - When tick == FRAME_TICKS-1: tick goes to 0, and frame_sel advances.
    - At the last frame (N_FRAMES-1) with loop_mode = 1: frame_sel wraps to 0 and the FSM stays in PLAY.
    - At the last frame with loop_mode = 0: go to DONE.
  - DONE: lasts one cycle. anim_done = 1, frame_sel returns to 0, then the FSM goes to IDLE.
- **Restart.** anim_start in PLAY or DONE restarts the animation: PLAY, frame_sel = 0, tick = 0. If anim_start and frame_begin arrive in the same cycle, anim_start wins and the tick is not counted.
- **Mode change.** loop_mode is sampled at the last-frame boundary, so a change during play is legal.
- **Degenerate case.** With N_FRAMES = 1 and loop_mode = 1, frame_sel stays at 0.

## Timing
- **Latency.** Two cycles from pixel_index to oled_colour/opaque. The pipeline is fully pipelined and accepts one pixel per cycle with no stalls.
- **Reset.** All of the following hold on the cycle after reset is asserted, and reset mid-animation aborts with no anim_done:
  - oled_colour = 0, opaque = 0, rom_addr = 0
  - frame_sel = 0, anim_busy = 0, anim_done = 0
  - FSM in IDLE, tick = 0
  - shadow position = (0,0), shadow flip = 0
- **Frame advance.** A frame_sel change becomes visible in rom_addr on the cycle after the frame_begin that caused it. Pixel 0 of the new frame is addressed with the new frame_sel.
- **Shadow update.** New pos_x, pos_y and flip_h values take effect for pixels entering S1 on the cycle after frame_begin.
- **One-shot length.** From anim_start to anim_done is exactly N_FRAMES*FRAME_TICKS frame_begin pulses, plus one cycle.

## Test plan
- Sprite at (10,5), no flip, frame 0, ROM(a) = a: pixel_index 5*96+10 = 490 → two cycles later rom_addr was 0 and opaque = 1. Index 489 → opaque = 0 and oled_colour = 0.
- flip_h = 1 at (10,5): index 490 → rom_addr = 31. Changing flip_h mid-frame has no effect until the next frame_begin.
- Key colour: ROM word = 16'h0000 inside the box → opaque = 0. ROM word = 16'hF800 → opaque = 1, oled_colour = 16'hF800.
- One-shot with N_FRAMES = 4, FRAME_TICKS = 2: anim_start, then 8 frame_begin pulses. frame_sel steps 0,0,1,1,2,2,3,3, anim_done pulses once after the 8th pulse, and anim_busy falls.
- Loop mode: after 8 pulses frame_sel = 0 and anim_busy = 1. anim_start coincident with frame_begin at frame 2 → frame_sel = 0, tick = 0.
- Clipping/reset: pos_x = 80 → pixels at x in 80..95 are drawn and nothing wraps to x = 0..15. Assert reset mid-PLAY → all outputs 0 and no anim_done pulse.

Source files
------------

// File: rtl/sprite_animator_if.sv
// ROM bus between sprite_animator and its external synchronous bitmap ROM.
// rom_data is expected one cycle after rom_addr.
interface sprite_animator_if #(
    parameter int AW = 12
) ();
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/sprite_animator.sv
// Sprite renderer for the 96x64 RGB565 OLED path: position, horizontal flip,
// multi-frame animation and colour-key transparency over an external sync ROM.
module sprite_animator #(
    parameter int          SCREEN_W    = 96,
    parameter int          SCREEN_H    = 64,
    parameter int          SPR_W       = 32,
    parameter int          SPR_H       = 32,
    parameter int          N_FRAMES    = 4,
    parameter int          FRAME_TICKS = 6,
    parameter logic [15:0] KEY_COLOUR  = 16'h0000,
    parameter int          AW          = $clog2(N_FRAMES*SPR_W*SPR_H),
    localparam int         FSW         = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [12:0]             pixel_index,
    input  logic                    frame_begin,
    input  logic [6:0]              pos_x,
    input  logic [5:0]              pos_y,
    input  logic                    flip_h,
    input  logic                    loop_mode,
    input  logic                    anim_start,
    sprite_animator_if.master       rom,
    output logic [15:0]             oled_colour,
    output logic                    opaque,
    output logic [FSW-1:0]          frame_sel,
    output logic                    anim_busy,
    output logic                    anim_done
);
    localparam int             TW       = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [AW-1:0]  FRAME_SZ = AW'(SPR_W*SPR_H);

    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DONE = 2'd2} state_t;

    state_t         state_r, state_s;
    logic [TW-1:0]  tick_r, tick_s;
    logic [FSW-1:0] fsel_r, fsel_s;
    logic [6:0]     sx_r, sx_s;
    logic [5:0]     sy_r, sy_s;
    logic           flip_r, flip_s;
    logic [7:0]     x_s, y_s, sx8_s, sy8_s, dx_s, lx_s, ly_s;
    logic           in_box_s, in_box_r, in_box_d_r;
    logic [AW-1:0]  addr_s;

    // Shadow next values: a pixel presented alongside frame_begin already sees the new position.
    always_comb begin
        if (frame_begin) begin
            sx_s   = pos_x;
            sy_s   = pos_y;
            flip_s = flip_h;
        end else begin
            sx_s   = sx_r;
            sy_s   = sy_r;
            flip_s = flip_r;
        end
    end

    // Animation FSM next state; anim_start outranks a coincident frame_begin.
    always_comb begin
        state_s = state_r;
        tick_s  = tick_r;
        fsel_s  = fsel_r;
        case (state_r)
            IDLE: begin
                tick_s = {TW{1'b0}};
                fsel_s = {FSW{1'b0}};
                if (anim_start) begin
                    state_s = PLAY;
                end else begin
                    state_s = IDLE;
                end
            end
            PLAY: begin
                if (anim_start) begin
                    tick_s = {TW{1'b0}};
                    fsel_s = {FSW{1'b0}};
                end else if (frame_begin) begin
                    if (tick_r == TW'(FRAME_TICKS-1)) begin
                        tick_s = {TW{1'b0}};
                        if (fsel_r == FSW'(N_FRAMES-1)) begin
                            fsel_s = {FSW{1'b0}};
                            if (loop_mode) begin
                                state_s = PLAY;
                            end else begin
                                state_s = DONE;
                            end
                        end else begin
                            fsel_s = fsel_r + FSW'(1);
                        end
                    end else begin
                        tick_s = tick_r + TW'(1);
                    end
                end else begin
                    tick_s = tick_r;
                end
            end
            DONE: begin
                tick_s = {TW{1'b0}};
                fsel_s = {FSW{1'b0}};
                if (anim_start) begin
                    state_s = PLAY;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
                tick_s  = {TW{1'b0}};
                fsel_s  = {FSW{1'b0}};
            end
        endcase
    end

    // S0 raster decode and S1 box test / address arithmetic, all at 8 bits so sx+SPR_W cannot wrap.
    always_comb begin
        x_s      = 8'(pixel_index % 13'(SCREEN_W));
        y_s      = 8'(pixel_index / 13'(SCREEN_W));
        sx8_s    = {1'b0, sx_s};
        sy8_s    = {2'b00, sy_s};
        in_box_s = (x_s >= sx8_s) && (x_s < sx8_s + 8'(SPR_W)) &&
                   (y_s >= sy8_s) && (y_s < sy8_s + 8'(SPR_H)) &&
                   (y_s < 8'(SCREEN_H));
        dx_s     = x_s - sx8_s;
        if (flip_s) begin
            lx_s = 8'(SPR_W-1) - dx_s;
        end else begin
            lx_s = dx_s;
        end
        ly_s     = y_s - sy8_s;
        addr_s   = AW'(fsel_s) * FRAME_SZ + AW'(ly_s) * AW'(SPR_W) + AW'(lx_s);
    end

    // State, shadow and pipeline registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            tick_r       <= {TW{1'b0}};
            fsel_r       <= {FSW{1'b0}};
            sx_r         <= 7'd0;
            sy_r         <= 6'd0;
            flip_r       <= 1'b0;
            in_box_r     <= 1'b0;
            in_box_d_r   <= 1'b0;
            rom.rom_addr <= {AW{1'b0}};
        end else begin
            state_r      <= state_s;
            tick_r       <= tick_s;
            fsel_r       <= fsel_s;
            sx_r         <= sx_s;
            sy_r         <= sy_s;
            flip_r       <= flip_s;
            in_box_r     <= in_box_s;
            in_box_d_r   <= in_box_r;
            rom.rom_addr <= in_box_s ? addr_s : {AW{1'b0}};
        end
    end

    // The ROM's own data register forms S2 together with in_box_d_r, giving two-cycle latency.
    assign opaque      = in_box_d_r && (rom.rom_data != KEY_COLOUR);
    assign oled_colour = opaque ? rom.rom_data : 16'h0000;
    assign frame_sel   = fsel_r;
    assign anim_busy   = (state_r == PLAY);
    assign anim_done   = (state_r == DONE);
endmodule

// File: tb/tb_sprite_animator.sv
// Directed bench for sprite_animator: sync ROM model holding (addr | 16'h8000)
// so every untouched word differs from the key colour.
module tb_sprite_animator;
    localparam int AW = 12;

    logic        clk = 1'b0;
    logic        reset, frame_begin, flip_h, loop_mode, anim_start;
    logic [12:0] pixel_index;
    logic [6:0]  pos_x;
    logic [5:0]  pos_y;
    logic [15:0] oled_colour;
    logic        opaque, anim_busy, anim_done;
    logic [1:0]  frame_sel;
    logic [15:0] rom_mem [0:4095];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    sprite_animator_if #(.AW(AW)) rom_if ();

    sprite_animator #(.N_FRAMES(4), .FRAME_TICKS(2)) dut (
        .clk(clk), .reset(reset), .pixel_index(pixel_index), .frame_begin(frame_begin),
        .pos_x(pos_x), .pos_y(pos_y), .flip_h(flip_h), .loop_mode(loop_mode),
        .anim_start(anim_start), .rom(rom_if), .oled_colour(oled_colour), .opaque(opaque),
        .frame_sel(frame_sel), .anim_busy(anim_busy), .anim_done(anim_done)
    );

    always @(posedge clk) rom_if.rom_data <= rom_mem[rom_if.rom_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_fb();
        frame_begin = 1'b1;
        step();
        frame_begin = 1'b0;
    endtask

    task automatic pix(input logic [12:0] idx, output logic [AW-1:0] a, output logic op, output logic [15:0] col);
        pixel_index = idx;
        step();
        a = rom_if.rom_addr;
        step();
        op  = opaque;
        col = oled_colour;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        total++; if (oled_colour !== 16'h0000) begin bad++; $display("FAIL reset_colour got=%h want=0000", oled_colour); end
        total++; if (opaque !== 1'b0) begin bad++; $display("FAIL reset_opaque got=%b want=0", opaque); end
        total++; if (rom_if.rom_addr !== 12'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", rom_if.rom_addr); end
        total++; if ({frame_sel, anim_busy, anim_done} !== 4'b0000) begin bad++; $display("FAIL reset_anim got=%b want=0000", {frame_sel, anim_busy, anim_done}); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_position();
        logic [AW-1:0] a; logic op; logic [15:0] c;
        pos_x = 7'd10; pos_y = 6'd5; flip_h = 1'b0;
        pulse_fb();
        pix(13'd490, a, op, c);
        total++; if (a !== 12'd0) begin bad++; $display("FAIL pos_addr490 got=%0d want=0", a); end
        total++; if ({op, c} !== {1'b1, 16'h8000}) begin bad++; $display("FAIL pos_pix490 got=%b/%h want=1/8000", op, c); end
        pix(13'd489, a, op, c);
        total++; if ({op, c, a} !== {1'b0, 16'h0000, 12'd0}) begin bad++; $display("FAIL pos_pix489 got=%b/%h/%0d want=0/0000/0", op, c, a); end
        pix(13'd3497, a, op, c);
        total++; if ({op, c, a} !== {1'b1, 16'h83FF, 12'd1023}) begin bad++; $display("FAIL pos_corner got=%b/%h/%0d want=1/83ff/1023", op, c, a); end
        pix(13'd522, a, op, c);
        total++; if (op !== 1'b0) begin bad++; $display("FAIL pos_right_edge got=%b want=0", op); end
    endtask

    task automatic test_flip();
        logic [AW-1:0] a; logic op; logic [15:0] c;
        flip_h = 1'b1;
        pix(13'd490, a, op, c);
        total++; if (a !== 12'd0) begin bad++; $display("FAIL flip_before_fb got=%0d want=0", a); end
        pulse_fb();
        pix(13'd490, a, op, c);
        total++; if ({a, c} !== {12'd31, 16'h801F}) begin bad++; $display("FAIL flip_490 got=%0d/%h want=31/801f", a, c); end
        pix(13'd491, a, op, c);
        total++; if (a !== 12'd30) begin bad++; $display("FAIL flip_491 got=%0d want=30", a); end
        flip_h = 1'b0; pos_x = 7'd0;
        pix(13'd490, a, op, c);
        total++; if (a !== 12'd31) begin bad++; $display("FAIL shadow_hold got=%0d want=31", a); end
    endtask

    task automatic test_key();
        logic [AW-1:0] a; logic op; logic [15:0] c;
        pos_x = 7'd10; pos_y = 6'd5; flip_h = 1'b0;
        pulse_fb();
        rom_mem[5] = 16'h0000;
        rom_mem[6] = 16'hF800;
        pix(13'd495, a, op, c);
        total++; if ({op, c} !== {1'b0, 16'h0000}) begin bad++; $display("FAIL key_transparent got=%b/%h want=0/0000", op, c); end
        pix(13'd496, a, op, c);
        total++; if ({op, c} !== {1'b1, 16'hF800}) begin bad++; $display("FAIL key_red got=%b/%h want=1/f800", op, c); end
        rom_mem[5] = 16'h8005;
        rom_mem[6] = 16'h8006;
    endtask

    task automatic test_clip();
        logic [AW-1:0] a; logic op; logic [15:0] c;
        pos_x = 7'd80; pos_y = 6'd0;
        pulse_fb();
        pix(13'd95, a, op, c);
        total++; if ({op, a} !== {1'b1, 12'd15}) begin bad++; $display("FAIL clip_x95 got=%b/%0d want=1/15", op, a); end
        pix(13'd0, a, op, c);
        total++; if (op !== 1'b0) begin bad++; $display("FAIL clip_wrap_x0 got=%b want=0", op); end
        pix(13'd111, a, op, c);
        total++; if (op !== 1'b0) begin bad++; $display("FAIL clip_wrap_x15 got=%b want=0", op); end
        pix(13'd191, a, op, c);
        total++; if ({op, a} !== {1'b1, 12'd47}) begin bad++; $display("FAIL clip_row1 got=%b/%0d want=1/47", op, a); end
    endtask

    task automatic test_oneshot();
        pos_x = 7'd10; pos_y = 6'd5; flip_h = 1'b0; loop_mode = 1'b0;
        pixel_index = 13'd490;
        anim_start = 1'b1; step(); anim_start = 1'b0;
        total++; if ({anim_busy, frame_sel} !== 3'b100) begin bad++; $display("FAIL os_start got=%b want=100", {anim_busy, frame_sel}); end
        for (int k = 1; k <= 8; k++) begin
            total++; if ({frame_sel, anim_done} !== {2'((k-1)/2), 1'b0}) begin bad++; $display("FAIL os_before_%0d got=%0d/%b want=%0d/0", k, frame_sel, anim_done, (k-1)/2); end
            pulse_fb();
            total++; if (rom_if.rom_addr !== 12'(((k/2)%4)*1024)) begin bad++; $display("FAIL os_addr_%0d got=%0d want=%0d", k, rom_if.rom_addr, ((k/2)%4)*1024); end
        end
        total++; if ({anim_done, anim_busy, frame_sel} !== 4'b1000) begin bad++; $display("FAIL os_done got=%b want=1000", {anim_done, anim_busy, frame_sel}); end
        step();
        total++; if ({anim_done, anim_busy} !== 2'b00) begin bad++; $display("FAIL os_after got=%b want=00", {anim_done, anim_busy}); end
    endtask

    task automatic test_loop();
        loop_mode = 1'b1;
        anim_start = 1'b1; step(); anim_start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            pulse_fb();
            total++; if (frame_sel !== 2'((k/2)%4)) begin bad++; $display("FAIL loop_fs_%0d got=%0d want=%0d", k, frame_sel, (k/2)%4); end
        end
        total++; if ({anim_busy, anim_done} !== 2'b10) begin bad++; $display("FAIL loop_busy got=%b want=10", {anim_busy, anim_done}); end
        for (int k = 0; k < 4; k++) pulse_fb();
        total++; if (frame_sel !== 2'd2) begin bad++; $display("FAIL loop_at2 got=%0d want=2", frame_sel); end
        anim_start = 1'b1; frame_begin = 1'b1; step(); anim_start = 1'b0; frame_begin = 1'b0;
        total++; if ({anim_busy, frame_sel} !== 3'b100) begin bad++; $display("FAIL restart got=%b want=100", {anim_busy, frame_sel}); end
        pulse_fb();
        total++; if (frame_sel !== 2'd0) begin bad++; $display("FAIL restart_tick0 got=%0d want=0", frame_sel); end
        pulse_fb();
        total++; if (frame_sel !== 2'd1) begin bad++; $display("FAIL restart_tick1 got=%0d want=1", frame_sel); end
        loop_mode = 1'b0;
        for (int k = 0; k < 5; k++) pulse_fb();
        total++; if ({frame_sel, anim_done} !== 3'b110) begin bad++; $display("FAIL mode_p5 got=%b want=110", {frame_sel, anim_done}); end
        pulse_fb();
        total++; if ({anim_done, anim_busy} !== 2'b10) begin bad++; $display("FAIL mode_done got=%b want=10", {anim_done, anim_busy}); end
        step();
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] a; logic op; logic [15:0] c;
        logic seen_done;
        loop_mode = 1'b0;
        pixel_index = 13'd490;
        anim_start = 1'b1; step(); anim_start = 1'b0;
        for (int k = 0; k < 3; k++) pulse_fb();
        total++; if ({anim_busy, frame_sel} !== 3'b101) begin bad++; $display("FAIL mid_pre got=%b want=101", {anim_busy, frame_sel}); end
        reset = 1'b1; step();
        total++; if ({frame_sel, anim_busy, anim_done, opaque, oled_colour, rom_if.rom_addr} !== 33'd0) begin bad++; $display("FAIL mid_reset got=%0d/%b/%b/%b/%h/%0d want all 0", frame_sel, anim_busy, anim_done, opaque, oled_colour, rom_if.rom_addr); end
        reset = 1'b0;
        seen_done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (anim_done) seen_done = 1'b1;
        end
        total++; if (seen_done !== 1'b0) begin bad++; $display("FAIL mid_no_done got=%b want=0", seen_done); end
        pix(13'd0, a, op, c);
        total++; if ({op, a} !== {1'b1, 12'd0}) begin bad++; $display("FAIL shadow_reset0 got=%b/%0d want=1/0", op, a); end
        pix(13'd490, a, op, c);
        total++; if (a !== 12'd170) begin bad++; $display("FAIL shadow_reset490 got=%0d want=170", a); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom_mem[i] = 16'(i) | 16'h8000;
        reset = 1'b1; frame_begin = 1'b0; flip_h = 1'b0; loop_mode = 1'b0; anim_start = 1'b0;
        pixel_index = 13'd0; pos_x = 7'd0; pos_y = 6'd0;
        test_reset();
        test_position();
        test_flip();
        test_key();
        test_clip();
        test_oneshot();
        test_loop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
